// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage RISC-V pipeline. It merges
//   the DMEM busy-wait, the IMEM busy-wait, load-use hazards and taken
//   branches into per-stage hold/flush controls. A branch that resolves
//   during a DMEM stall is remembered (BR_PEND) and applied when the stall
//   ends. It also provides a sticky stall watchdog and optional performance
//   counters.
//
//   Optional feature macro: HAZARD_PERF_EN (performance counters). When it
//   is undefined, the PERF_* ports are tied to 0.
//
// Ports
//   CLK, reset            clock, synchronous active-high reset
//   ID_RS1/2, ID_USES_RS1/2  source operands of the instruction in ID
//   EX_RD, EX_MEM_READ    destination and load flag of the instruction in EX
//   EX_BRANCH_TAKEN       the EX branch/jump redirects this cycle
//   IMEM_BUSY, DMEM_BUSY  memory busy-wait flags
//   PC_WRITE_EN           PC may update
//   *_HOLD                pipeline register keeps its value
//   IF_ID/ID_EX_FLUSH     pipeline register loads a bubble
//   BRANCH_REDIRECT       PC mux selects the branch target
//   TIMEOUT_ERR           sticky watchdog error
//   STATE                 0 RUN, 1 DWAIT, 2 BR_PEND
//   PERF_*                stall / flush / load-use counters
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_MEM_READ,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        IMEM_BUSY,
    input  logic        DMEM_BUSY,
    output logic        PC_WRITE_EN,
    output logic        IF_ID_HOLD,
    output logic        ID_EX_HOLD,
    output logic        EX_MEM_HOLD,
    output logic        MEM_WB_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        BRANCH_REDIRECT,
    output logic        TIMEOUT_ERR,
    output logic [1:0]  STATE,
    output logic [31:0] PERF_STALLS,
    output logic [31:0] PERF_FLUSHES,
    output logic [31:0] PERF_LOADUSE
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        BR_PEND = 2'd2
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_wd;
    logic [15:0] w_wd_inc;
    logic        r_tmo_err;
    logic        w_lu;
    logic        w_br_eff;
    logic        w_lu_bubble;
    logic        w_if_id_fl_raw;
    logic        w_id_ex_fl_raw;

    assign w_lu = EX_MEM_READ && (EX_RD != 5'd0) &&
                  ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                   (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    // A pending branch is treated exactly like a fresh taken branch.
    assign w_br_eff = EX_BRANCH_TAKEN || (r_state == BR_PEND);

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (DMEM_BUSY) w_state_nxt = EX_BRANCH_TAKEN ? BR_PEND : DWAIT;
            end
            DWAIT: begin
                if (!DMEM_BUSY)           w_state_nxt = RUN;
                else if (EX_BRANCH_TAKEN) w_state_nxt = BR_PEND;
            end
            BR_PEND: begin
                // Redirect is issued combinationally in the first non-busy cycle.
                if (!DMEM_BUSY) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // ---------------- control outputs ----------------
    always_comb begin
        PC_WRITE_EN     = 1'b1;
        IF_ID_HOLD      = 1'b0;
        ID_EX_HOLD      = 1'b0;
        EX_MEM_HOLD     = 1'b0;
        MEM_WB_HOLD     = 1'b0;
        w_if_id_fl_raw  = 1'b0;
        w_id_ex_fl_raw  = 1'b0;
        BRANCH_REDIRECT = 1'b0;
        w_lu_bubble     = 1'b0;

        if (DMEM_BUSY) begin
            PC_WRITE_EN = 1'b0;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
        end else if (w_br_eff) begin
            // Also covers IMEM_BUSY: the IF/ID flush hides the missing fetch.
            BRANCH_REDIRECT = 1'b1;
            w_if_id_fl_raw  = 1'b1;
            w_id_ex_fl_raw  = 1'b1;
        end else if (w_lu) begin
            PC_WRITE_EN    = 1'b0;
            IF_ID_HOLD     = 1'b1;
            w_id_ex_fl_raw = 1'b1;
            w_lu_bubble    = 1'b1;
        end else if (IMEM_BUSY) begin
            PC_WRITE_EN    = 1'b0;
            w_if_id_fl_raw = 1'b1;
        end

        // Hold wins over flush on the same register.
        IF_ID_FLUSH = w_if_id_fl_raw && !IF_ID_HOLD;
        ID_EX_FLUSH = w_id_ex_fl_raw && !ID_EX_HOLD;

        // During reset the pipeline is drained with bubbles and the PC frozen.
        if (reset) begin
            PC_WRITE_EN     = 1'b0;
            IF_ID_HOLD      = 1'b0;
            ID_EX_HOLD      = 1'b0;
            EX_MEM_HOLD     = 1'b0;
            MEM_WB_HOLD     = 1'b0;
            IF_ID_FLUSH     = 1'b1;
            ID_EX_FLUSH     = 1'b1;
            BRANCH_REDIRECT = 1'b0;
            w_lu_bubble     = 1'b0;
        end
    end

    assign STATE = r_state;

    // ---------------- watchdog ----------------
    assign w_wd_inc = (r_wd == 16'hFFFF) ? r_wd : r_wd + 16'd1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wd      <= 16'd0;
            r_tmo_err <= 1'b0;
        end else begin
            r_wd <= DMEM_BUSY ? w_wd_inc : 16'd0;
            if (DMEM_BUSY && (w_wd_inc >= TMO)) r_tmo_err <= 1'b1;
        end
    end

    assign TIMEOUT_ERR = r_tmo_err;

    // ---------------- performance counters ----------------
`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stalls;
    logic [31:0] r_perf_flushes;
    logic [31:0] r_perf_loaduse;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_perf_stalls  <= 32'd0;
            r_perf_flushes <= 32'd0;
            r_perf_loaduse <= 32'd0;
        end else begin
            if (!PC_WRITE_EN)    r_perf_stalls  <= r_perf_stalls + 32'd1;
            if (BRANCH_REDIRECT) r_perf_flushes <= r_perf_flushes + 32'd1;
            if (w_lu_bubble)     r_perf_loaduse <= r_perf_loaduse + 32'd1;
        end
    end

    assign PERF_STALLS  = r_perf_stalls;
    assign PERF_FLUSHES = r_perf_flushes;
    assign PERF_LOADUSE = r_perf_loaduse;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_lu_bubble;
    assign PERF_STALLS   = 32'd0;
    assign PERF_FLUSHES  = 32'd0;
    assign PERF_LOADUSE  = 32'd0;
`endif

endmodule
